// File: rtl/serial_pkg.sv
// -----------------------------------------------------------------------------
// serial_pkg
// Definitions shared by the serial receiver and the matching transmitter:
// FSM state encoding and the line levels for idle and start bit.
// -----------------------------------------------------------------------------
package serial_pkg;

   // State encoding. The values are fixed so the transmitter and any debug
   // tooling that decodes a raw state register see the same numbers.
   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] STOP   = 3'd3;
   localparam logic [2:0] PARITY = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE   = IDLE,
      ST_START  = START,
      ST_DATA   = DATA,
      ST_STOP   = STOP,
      ST_PARITY = PARITY
   } state_t;

   // The line idles high; a start bit pulls it low.
   localparam logic IDLE_LEVEL  = 1'b1;
   localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/serial_bit_timer.sv
// -----------------------------------------------------------------------------
// serial_bit_timer
// Down-counter that measures bit periods for the serial receiver.
//
// Ports:
//   clk        in   system clock, posedge
//   rst_n      in   synchronous active-low reset (counter cleared)
//   load_half  in   load CLKS_PER_BIT/2-1: tick lands in the middle of a bit
//   load_full  in   load CLKS_PER_BIT-1: tick lands one bit period later
//   tick       out  counter at terminal count (zero)
//
// After a load at edge N the tick is seen while the FSM evaluates edge
// N+CLKS_PER_BIT/2 (half) or N+CLKS_PER_BIT (full). Without a load the counter
// parks at zero rather than wrapping.
// -----------------------------------------------------------------------------
module serial_bit_timer
   import serial_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load_half,
   input  logic load_full,
   output logic tick
);

   localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_full) begin
         cnt_d = FULL_M1;
      end else if (load_half) begin
         cnt_d = HALF_M1;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = (cnt_q == '0);

endmodule

// File: rtl/serial_receiver.sv
// -----------------------------------------------------------------------------
// serial_receiver
// Turns an idle-high serial stream (start 0, DATA_W data bits LSB first,
// stop 1, each bit CLKS_PER_BIT clocks long) back into parallel words.
//
// Ports:
//   clk        in   system clock, posedge
//   rst_n      in   synchronous active-low reset; aborts a frame in flight
//   in         in   serial line, idle high, synchronous to clk
//   out        out  [DATA_W] last correctly received word
//   valid      out  one-cycle pulse, out updated this cycle
//   frame_err  out  one-cycle pulse, stop bit sampled low (out unchanged)
//   busy       out  high while a frame is being received
//   parity_err out  one-cycle pulse, parity mismatch with a good stop bit
//                   (only with SERIAL_RECEIVER_PARITY_EN defined)
//
// Optional feature: define SERIAL_RECEIVER_PARITY_EN to expect one even-parity
// bit between the last data bit and the stop bit.
//
// Latency: let t0 be the clock edge at which the first low level of the start
// bit is sampled. The stop bit is sampled at edge
//   t0 + CLKS_PER_BIT/2 + (DATA_W+1)*CLKS_PER_BIT
// (one more CLKS_PER_BIT with parity enabled) and valid/frame_err/parity_err
// are registered at that same edge, i.e. high in the cycle right after it.
// No extra cycle is added.
//
// After a framing error the receiver is disarmed: it will not start a new
// frame until it has seen the line high while idle, so a held-low line
// (break) gives exactly one frame_err.
// -----------------------------------------------------------------------------
module serial_receiver
   import serial_pkg::*;
#(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in,
   output logic [DATA_W-1:0] out,
   output logic              valid,
   output logic              frame_err,
   output logic              busy
`ifdef SERIAL_RECEIVER_PARITY_EN
   ,
   output logic              parity_err
`endif
);

   localparam int BW = (DATA_W > 1) ? $clog2(DATA_W + 1) : 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

   state_t            state_q, state_d;
   logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [DATA_W-1:0] out_q, out_d;
   logic              valid_q, valid_d;
   logic              frame_err_q, frame_err_d;
   logic              busy_q, busy_d;
   logic              armed_q, armed_d;
   logic              par_ok;
   logic              load_half, load_full, tick;

`ifdef SERIAL_RECEIVER_PARITY_EN
   logic              par_q, par_d;
   logic              parity_err_q, parity_err_d;
   // Even parity: data bits plus parity bit hold an even number of ones.
   assign par_ok = ~(^{shift_q, par_q});
`else
   assign par_ok = 1'b1;
`endif

   serial_bit_timer #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_half (load_half),
      .load_full (load_full),
      .tick      (tick)
   );

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      out_d       = out_q;
      valid_d     = 1'b0;
      frame_err_d = 1'b0;
      armed_d     = armed_q;
      load_half   = 1'b0;
      load_full   = 1'b0;
`ifdef SERIAL_RECEIVER_PARITY_EN
      par_d        = par_q;
      parity_err_d = 1'b0;
`endif

      case (state_q)
         ST_IDLE: begin
            if (in == IDLE_LEVEL) begin
               armed_d = 1'b1;
            end else if (armed_q) begin
               // Falling edge seen: first tick comes at mid start bit.
               state_d   = ST_START;
               load_half = 1'b1;
            end
         end

         ST_START: begin
            if (tick) begin
               if (in == IDLE_LEVEL) begin
                  state_d = ST_IDLE;             // glitch, not a start bit
               end else begin
                  state_d   = ST_DATA;
                  load_full = 1'b1;
                  bit_cnt_d = '0;
               end
            end
         end

         ST_DATA: begin
            if (tick) begin
               // LSB arrives first, so shift right and enter at the MSB.
               shift_d             = shift_q >> 1;
               shift_d[DATA_W-1]   = in;
               load_full           = 1'b1;
               if (bit_cnt_q == LAST_BIT) begin
                  bit_cnt_d = '0;
`ifdef SERIAL_RECEIVER_PARITY_EN
                  state_d   = ST_PARITY;
`else
                  state_d   = ST_STOP;
`endif
               end else begin
                  bit_cnt_d = bit_cnt_q + BW'(1);
               end
            end
         end

`ifdef SERIAL_RECEIVER_PARITY_EN
         ST_PARITY: begin
            if (tick) begin
               par_d     = in;
               load_full = 1'b1;
               state_d   = ST_STOP;
            end
         end
`endif

         ST_STOP: begin
            if (tick) begin
               // Back to IDLE at mid stop bit so an immediately following
               // start bit is caught on its first low cycle.
               state_d = ST_IDLE;
               if (in != IDLE_LEVEL) begin
                  frame_err_d = 1'b1;
                  armed_d     = 1'b0;
               end else if (par_ok) begin
                  out_d   = shift_q;
                  valid_d = 1'b1;
               end
`ifdef SERIAL_RECEIVER_PARITY_EN
               else begin
                  parity_err_d = 1'b1;
               end
`endif
            end
         end

         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         out_q       <= '0;
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;
         busy_q      <= 1'b0;
         armed_q     <= 1'b1;
`ifdef SERIAL_RECEIVER_PARITY_EN
         par_q        <= 1'b0;
         parity_err_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         out_q       <= out_d;
         valid_q     <= valid_d;
         frame_err_q <= frame_err_d;
         busy_q      <= busy_d;
         armed_q     <= armed_d;
`ifdef SERIAL_RECEIVER_PARITY_EN
         par_q        <= par_d;
         parity_err_q <= parity_err_d;
`endif
      end
   end

   assign out       = out_q;
   assign valid     = valid_q;
   assign frame_err = frame_err_q;
   assign busy      = busy_q;
`ifdef SERIAL_RECEIVER_PARITY_EN
   assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_serial_receiver.sv
// -----------------------------------------------------------------------------
// tb_serial_receiver
// Drives framed serial words into serial_receiver. Each frame's expected
// outcome (pulse kind, word on out, cycle of the pulse) is derived from the
// frame contents and queued; a monitor pops and compares on every pulse.
// -----------------------------------------------------------------------------
module tb_serial_receiver;

   localparam int DATA_W = 8;
   localparam int CPB    = 16;
`ifdef SERIAL_RECEIVER_PARITY_EN
   localparam int EXTRA  = 1;
`else
   localparam int EXTRA  = 0;
`endif
   localparam int LAT = CPB / 2 + (DATA_W + 1 + EXTRA) * CPB;

   localparam int K_VALID = 0;
   localparam int K_FERR  = 1;
   localparam int K_PERR  = 2;

   typedef struct {
      int                kind;
      logic [DATA_W-1:0] data;
      longint            cyc;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              in = 1'b1;
   logic [DATA_W-1:0] out;
   logic              valid;
   logic              frame_err;
   logic              busy;
   logic              parity_err;

   int                errors = 0;
   int                checks = 0;
   longint            cyc = 0;
   logic [DATA_W-1:0] last_good = '0;
   exp_t              sbq[$];

   serial_receiver #(
      .DATA_W       (DATA_W),
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in        (in),
      .out       (out),
      .valid     (valid),
      .frame_err (frame_err),
      .busy      (busy)
`ifdef SERIAL_RECEIVER_PARITY_EN
      ,
      .parity_err(parity_err)
`endif
   );

`ifndef SERIAL_RECEIVER_PARITY_EN
   assign parity_err = 1'b0;
`endif

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input bit ok, input string name, input longint act, input longint req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: every pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      int   k;
      exp_t e;
      if (rst_n) begin
         if (valid && frame_err) chk(1'b0, "valid_with_frame_err", 1, 0);
         if (valid || frame_err || parity_err) begin
            k = valid ? K_VALID : (frame_err ? K_FERR : K_PERR);
            if (sbq.size() == 0) begin
               chk(1'b0, "unexpected_pulse_kind", k, -1);
            end else begin
               e = sbq.pop_front();
               chk(k == e.kind, "pulse_kind", k, e.kind);
               chk(out == e.data, "out_word", out, e.data);
               chk(cyc == e.cyc, "pulse_cycle", cyc, e.cyc);
            end
         end
      end
   end

   // All input changes happen 1 time unit after a rising edge.
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic idle(input int n);
      in = 1'b1;
      step(n);
   endtask

   task automatic drive_bit(input logic b);
      in = b;
      step(CPB);
   endtask

   // Sends one frame; the reference outcome comes from the frame contents:
   // a low stop bit is a framing error, a flipped parity bit is a parity
   // error, otherwise the word is delivered. The pulse is due LAT edges after
   // the edge that first samples the start bit.
   task automatic send_frame(input logic [DATA_W-1:0] d, input logic stop_b,
                             input logic par_flip);
      longint t0;
      exp_t   e;
      t0 = cyc + 1;
      drive_bit(1'b0);
      for (int i = 0; i < DATA_W; i++) drive_bit(d[i]);
`ifdef SERIAL_RECEIVER_PARITY_EN
      drive_bit(($countones(d) % 2 == 1) ^ par_flip);
`endif
      e.cyc  = t0 + LAT;
      e.data = last_good;
      if (!stop_b) begin
         e.kind = K_FERR;
      end else if (par_flip) begin
         e.kind = K_PERR;
      end else begin
         e.kind    = K_VALID;
         e.data    = d;
         last_good = d;
      end
      sbq.push_back(e);
      drive_bit(stop_b);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got %0d queued, expected 0", sbq.size());
      $fatal(1);
   end

   initial begin
      logic [DATA_W-1:0] rd;
      logic              bad_stop;
      logic              flip;
      longint            t0;
      exp_t              e;

      // Reset with the line toggling: everything stays zero.
      rst_n = 1'b0;
      step(1);
      for (int i = 0; i < 3; i++) begin
         in = (i % 2 == 0) ? 1'b0 : 1'b1;
         @(negedge clk);
         chk(out == '0, "reset_out", out, 0);
         chk({valid, frame_err, busy, parity_err} == 4'b0, "reset_flags",
             {valid, frame_err, busy, parity_err}, 0);
         @(posedge clk);
         #1;
      end
      rst_n = 1'b1;
      idle(40);
      chk(busy == 1'b0, "idle_busy", busy, 0);
      chk(out == '0, "idle_out", out, 0);

      // Single frame.
      send_frame(8'hA5, 1'b1, 1'b0);
      chk(sbq.size() == 0, "a5_pulse_seen", sbq.size(), 0);
      chk(busy == 1'b0, "a5_busy_after", busy, 0);
      chk(out == 8'hA5, "a5_out", out, 8'hA5);
      idle(4);

      // Back-to-back, no idle gap.
      send_frame(8'h00, 1'b1, 1'b0);
      send_frame(8'hFF, 1'b1, 1'b0);
      chk(sbq.size() == 0, "b2b_pulses_seen", sbq.size(), 0);
      chk(out == 8'hFF, "b2b_out", out, 8'hFF);
      idle(5);

      // Glitch of 4 low cycles: busy for a while, no pulse.
      in = 1'b0;
      step(2);
      chk(busy == 1'b1, "glitch_busy_high", busy, 1);
      step(2);
      idle(12);
      chk(busy == 1'b0, "glitch_busy_low", busy, 0);
      chk(out == 8'hFF, "glitch_out", out, 8'hFF);

      // Framing error: stop bit low.
      send_frame(8'h3C, 1'b0, 1'b0);
      idle(3);
      chk(sbq.size() == 0, "ferr_pulse_seen", sbq.size(), 0);
      chk(out == 8'hFF, "ferr_out_kept", out, 8'hFF);

      // Break: 300 low cycles give exactly one frame_err.
      t0     = cyc + 1;
      e.kind = K_FERR;
      e.data = last_good;
      e.cyc  = t0 + LAT;
      sbq.push_back(e);
      in = 1'b0;
      step(300);
      idle(20);
      chk(sbq.size() == 0, "break_pulse_seen", sbq.size(), 0);
      chk(busy == 1'b0, "break_busy_after", busy, 0);
      send_frame(8'h96, 1'b1, 1'b0);
      chk(out == 8'h96, "after_break_out", out, 8'h96);
      idle(4);

      // Reset during data bit 4 of 0x5A: frame dropped, outputs cleared.
      rd = 8'h5A;
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(rd[i]);
      in = rd[4];
      step(CPB / 2);
      rst_n = 1'b0;
      in    = 1'b1;
      step(2);
      chk(out == '0, "midreset_out", out, 0);
      chk({valid, frame_err, busy} == 3'b0, "midreset_flags", {valid, frame_err, busy}, 0);
      rst_n     = 1'b1;
      last_good = '0;
      idle(10);
      chk(busy == 1'b0, "midreset_idle", busy, 0);
      send_frame(8'h81, 1'b1, 1'b0);
      chk(out == 8'h81, "post_reset_out", out, 8'h81);
      idle(3);

`ifdef SERIAL_RECEIVER_PARITY_EN
      send_frame(8'h81, 1'b1, 1'b1);
      chk(sbq.size() == 0, "perr_pulse_seen", sbq.size(), 0);
      chk(out == 8'h81, "perr_out_kept", out, 8'h81);
      idle(3);
`endif

      // Random frames with occasional bad stop bits and random gaps.
      for (int n = 0; n < 25; n++) begin
         rd       = 8'($urandom);
         bad_stop = ($urandom_range(0, 5) == 0);
`ifdef SERIAL_RECEIVER_PARITY_EN
         flip     = ($urandom_range(0, 4) == 0);
`else
         flip     = 1'b0;
`endif
         send_frame(rd, ~bad_stop, flip);
         // After a framing error the line must be seen high to re-arm.
         if (bad_stop) idle($urandom_range(2, 10));
         else idle($urandom_range(0, 10));
      end
      chk(out == last_good, "random_final_out", out, last_good);

      // Bounded drain of anything still expected.
      for (int i = 0; i < 400 && sbq.size() != 0; i++) step(1);
      chk(sbq.size() == 0, "scoreboard_drain", sbq.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/serial_receiver.md
Name: serial_receiver

Overview:
- Receives the 1-bit serial stream produced by the lab serial driver/stimulus side and turns it back into parallel words.
- Frame on the line, idle-high: start bit (0), DATA_W data bits LSB first, stop bit (1).
- Each bit lasts CLKS_PER_BIT clock cycles.
- Sits between a 1-bit line input and any parallel consumer: LED display, register bank or testbench checker.

Parameters:
- DATA_W, 8, number of data bits per frame (1..16).
- CLKS_PER_BIT, 16, clock cycles per serial bit (>= 4, even).

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  synchronous, active-low reset.
- in  input  1  serial line, idle high; treated as synchronous to clk.
- out  output  DATA_W  last correctly received word.
- valid  output  1  one-cycle pulse: out updated this cycle.
- frame_err  output  1  one-cycle pulse: stop bit sampled as 0.
- busy  output  1  high while a frame is being received (state != IDLE).

Behaviour:
- One clock; reset is synchronous and active-low (ports clk, rst_n).
- Reset (rst_n low at posedge):
  - state=IDLE.
  - out=0, valid=0, frame_err=0, busy=0.
  - bit counter=0, cycle counter=0, shift register=0.
  - Reset mid-frame aborts the frame; no pulse is emitted.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: when in==0 is sampled, go to START and clear the cycle counter.
  - START: count to CLKS_PER_BIT/2-1 (mid start bit).
    - If in==1 there: false start; return to IDLE with no pulse.
    - Else go to DATA with the cycle counter cleared.
  - DATA: every CLKS_PER_BIT cycles (mid-bit), shift in into the MSB of the shift register (LSB-first framing).
    - After DATA_W samples, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample in.
    - in==1: out <= shift register, valid=1 for one cycle.
    - in==0: frame_err=1 for one cycle, out unchanged.
    - Either way, return to IDLE.
- Latency: valid rises CLKS_PER_BIT/2 + (DATA_W+1)*CLKS_PER_BIT cycles after the cycle in which the falling start edge is sampled (+-1 cycle, fixed by implementation, documented in RTL header).
- valid and frame_err are never high together; each is high for at most one cycle per frame.
- Back-to-back frames:
  - IDLE is re-entered at mid stop bit.
  - A start bit immediately following is detected with no lost cycle.
- Line held low (break):
  - Produces frame_err.
  - Receiver then stays in IDLE→START until the line returns high, then a new falling edge is required.
  - Re-arm only after in==1 has been seen in IDLE.
- Counter widths: $clog2(CLKS_PER_BIT) and $clog2(DATA_W+1); no wrap inside a bit.

Optional Feature:
- Macro: SERIAL_RECEIVER_PARITY_EN.
- Defined:
  - Frame carries one even-parity bit between the last data bit and the stop bit.
  - Extra state PARITY.
  - Extra output parity_err (1 bit, one-cycle pulse, reset 0).
  - On a parity mismatch with a good stop bit: parity_err=1, valid=0, out unchanged.
  - Latency grows by CLKS_PER_BIT.
- Undefined:
  - No PARITY state, no parity_err port.
  - Frame as above.

Decomposition:
- Shared package serial_pkg:
  - state encoding localparams (IDLE=0, START=1, DATA=2, STOP=3, PARITY=4).
  - IDLE_LEVEL=1'b1, START_LEVEL=1'b0.
  - Also used by the future matching transmitter.
- One natural sub-module: serial_bit_timer.
  - Cycle counter with load-half / load-full and a tick output at terminal count.
  - Instantiated once.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with in toggling → out=0, valid=0, frame_err=0, busy=0 throughout; after release, in=1 for 40 cycles → no pulses.
- Single frame: DATA_W=8, CLKS_PER_BIT=16, send 0xA5 → exactly one valid pulse, out=8'hA5, busy low after it; latency matches the documented formula.
- Back-to-back: 0x00 then 0xFF, zero idle gap → two valid pulses, out=8'h00 then 8'hFF, no frame_err.
- Glitch/false start: in=0 for 4 cycles, then 1 → busy pulses, returns to IDLE, no valid, no frame_err, out unchanged.
- Framing error: send 0x3C with stop bit 0 → frame_err pulse, out retains previous value, valid stays 0. Break (in=0 for 300 cycles) → one frame_err, no further pulses until in returns high and a new frame arrives.
- Reset mid-frame: assert rst_n=0 during data bit 4 of 0x5A → no pulse; all outputs zero; next full frame 0x81 received correctly. With SERIAL_RECEIVER_PARITY_EN: 0x81 sent with parity bit 1 → parity_err pulse, no valid.
